multi_clock_divider: RTL



---
 rtl/clkdiv_pkg.sv | 23 ++
 rtl/multi_clock_divider_channel.sv | 104 ++++++++++
 rtl/multi_clock_divider.sv | 34 +++
 3 files changed

// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared types, constants and divisor helpers for the clock divider
package clkdiv_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  localparam logic [31:0] MIN_DIV = 32'd2;

  // 0 means idle; 1 cannot make a two-level clock, so it runs as MIN_DIV.
  function automatic logic [31:0] eff_div(input logic [31:0] d);
    if (d == 32'd0) return 32'd0;
    else if (d < MIN_DIV) return MIN_DIV;
    else return d;
  endfunction

  // Odd periods carry the extra cycle in the high phase.
  function automatic logic [31:0] high_time(input logic [31:0] d);
    return d - (d >> 1);
  endfunction

endpackage

// File: rtl/multi_clock_divider_channel.sv
// rtl/multi_clock_divider_channel.sv - one programmable divided-clock channel
module clock_divider_channel #(
  parameter int WIDTH = 8
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] divider,
  input  logic             sync,
  output logic             clk_out,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic             active
);
  import clkdiv_pkg::*;

  ch_state_e        state, state_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] cur_div, cur_div_n;
  logic [WIDTH-1:0] pend_div, pend_div_n;
  logic             pend_valid, pend_valid_n;
  logic             clk_n, rise_n, fall_n;
  logic [31:0]      d_cur, h_cur, cnt_next32;
  logic [WIDTH-1:0] next_div;
  logic             start_ok, at_wrap;

  always_comb begin
    d_cur      = eff_div(32'(cur_div));
    h_cur      = high_time(d_cur);
    cnt_next32 = 32'(cnt) + 32'd1;
    // A load on a boundary cycle bypasses the pending register.
    next_div   = load ? divider : (pend_valid ? pend_div : cur_div);
    start_ok   = eff_div(32'(next_div)) != 32'd0;
    at_wrap    = (state == RUN) && (cnt_next32 == d_cur);

    state_n      = state;
    cnt_n        = cnt;
    cur_div_n    = cur_div;
    pend_div_n   = pend_div;
    pend_valid_n = pend_valid;
    clk_n        = clk_out;
    rise_n       = 1'b0;
    fall_n       = 1'b0;

    if (load) begin
      pend_div_n   = divider;
      pend_valid_n = 1'b1;
    end

    if (!en) begin
      state_n = IDLE;
      cnt_n   = '0;
      clk_n   = 1'b0;
      fall_n  = clk_out;
      if (pend_valid) begin
        cur_div_n    = pend_div;
        pend_valid_n = load;
      end
    end else if (sync || state == IDLE || at_wrap) begin
      cur_div_n    = next_div;
      pend_valid_n = 1'b0;
      cnt_n        = '0;
      if (start_ok) begin
        state_n = RUN;
        clk_n   = 1'b1;
        rise_n  = 1'b1;
      end else begin
        state_n = IDLE;
        clk_n   = 1'b0;
        fall_n  = clk_out;
      end
    end else begin
      cnt_n  = cnt + WIDTH'(1);
      clk_n  = cnt_next32 < h_cur;
      fall_n = cnt_next32 == h_cur;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      cur_div    <= '0;
      pend_div   <= '0;
      pend_valid <= 1'b0;
      clk_out    <= 1'b0;
      rise_tick  <= 1'b0;
      fall_tick  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      cur_div    <= cur_div_n;
      pend_div   <= pend_div_n;
      pend_valid <= pend_valid_n;
      clk_out    <= clk_n;
      rise_tick  <= rise_n;
      fall_tick  <= fall_n;
    end
  end

  assign active = (state == RUN);

endmodule

// File: rtl/multi_clock_divider.sv
// rtl/multi_clock_divider.sv - N-channel programmable clock-enable generator with shared sync
module multi_clock_divider #(
  parameter int NUM_CH = 2,
  parameter int WIDTH  = 8
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             en,
  input  logic [NUM_CH-1:0]             load,
  input  logic [NUM_CH-1:0][WIDTH-1:0]  divider,
  input  logic                          sync,
  output logic [NUM_CH-1:0]             clk_out,
  output logic [NUM_CH-1:0]             rise_tick,
  output logic [NUM_CH-1:0]             fall_tick,
  output logic [NUM_CH-1:0]             active
);
  import clkdiv_pkg::*;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clock_divider_channel #(.WIDTH(WIDTH)) u_ch (
      .CLOCK_50  (CLOCK_50),
      .reset     (reset),
      .en        (en[i]),
      .load      (load[i]),
      .divider   (divider[i]),
      .sync      (sync),
      .clk_out   (clk_out[i]),
      .rise_tick (rise_tick[i]),
      .fall_tick (fall_tick[i]),
      .active    (active[i])
    );
  end

endmodule
